// File: rtl/range_counter_ctrl.sv
// Bounded up/down sweep counter: a configuration handshake latches [lo,hi], the direction and
// the sweep count; start then runs sweeps with pause/abort control and wrap/done pulses.
module range_counter_ctrl #(
    parameter int WIDTH  = 8,
    parameter int PASS_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WIDTH-1:0]  cfg_lo,
    input  logic [WIDTH-1:0]  cfg_hi,
    input  logic [PASS_W-1:0] cfg_passes,
    input  logic              cfg_down,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              wrap,
    output logic              done,
    output logic              cfg_err
);

    typedef enum logic [1:0] {IDLE, ARMED, RUN, PAUSE} state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   count_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [PASS_W-1:0]  passes_reg;
    logic [PASS_W-1:0]  pass_cnt_reg;
    logic               down_reg;
    logic               busy_reg;
    logic               cfg_ready_reg;
    logic               wrap_reg;
    logic               done_reg;
    logic               cfg_err_reg;

    logic [WIDTH-1:0]   start_val;
    logic [WIDTH-1:0]   end_val;
    logic [WIDTH-1:0]   cfg_start_val;
    logic [PASS_W:0]    pass_cnt_inc;
    logic               cfg_ok;
    logic               sweeps_left;
    logic               out_of_range;

    assign start_val     = down_reg ? hi_reg : lo_reg;
    assign end_val       = down_reg ? lo_reg : hi_reg;
    assign cfg_start_val = cfg_down ? cfg_hi : cfg_lo;
    assign cfg_ok        = (cfg_lo <= cfg_hi);
    // One extra bit so pass_cnt + 1 cannot overflow before the comparison.
    assign pass_cnt_inc  = {1'b0, pass_cnt_reg} + {{PASS_W{1'b0}}, 1'b1};
    assign sweeps_left   = (passes_reg == '0) || (pass_cnt_inc < {1'b0, passes_reg});
    assign out_of_range  = (count_reg < lo_reg) || (count_reg > hi_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            lo_reg        <= '0;
            hi_reg        <= '0;
            passes_reg    <= '0;
            pass_cnt_reg  <= '0;
            down_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            cfg_ready_reg <= 1'b1;
            wrap_reg      <= 1'b0;
            done_reg      <= 1'b0;
            cfg_err_reg   <= 1'b0;
        end else begin
            wrap_reg    <= 1'b0;
            done_reg    <= 1'b0;
            cfg_err_reg <= 1'b0;
            case (state_reg)
                IDLE, ARMED: begin
                    if (state_reg == ARMED && abort) begin
                        state_reg <= IDLE;
                    end else begin
                        // An accepted handshake is always acted on, even alongside start.
                        if (cfg_valid) begin
                            if (!cfg_ok) begin
                                cfg_err_reg <= 1'b1;
                            end else begin
                                lo_reg       <= cfg_lo;
                                hi_reg       <= cfg_hi;
                                passes_reg   <= cfg_passes;
                                down_reg     <= cfg_down;
                                count_reg    <= cfg_start_val;
                                pass_cnt_reg <= '0;
                                state_reg    <= ARMED;
                            end
                        end
                        if (state_reg == ARMED && start) begin
                            state_reg     <= RUN;
                            busy_reg      <= 1'b1;
                            cfg_ready_reg <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_reg     <= IDLE;
                        busy_reg      <= 1'b0;
                        cfg_ready_reg <= 1'b1;
                    end else if (pause) begin
                        state_reg <= PAUSE;
                    end else if (out_of_range) begin
                        count_reg <= start_val;
                    end else if (count_reg == end_val) begin
                        if (sweeps_left) begin
                            count_reg <= start_val;
                            wrap_reg  <= 1'b1;
                            if (!(&pass_cnt_reg)) begin
                                pass_cnt_reg <= pass_cnt_reg + 1'b1;
                            end
                        end else begin
                            done_reg      <= 1'b1;
                            state_reg     <= IDLE;
                            busy_reg      <= 1'b0;
                            cfg_ready_reg <= 1'b1;
                        end
                    end else if (down_reg) begin
                        count_reg <= count_reg - 1'b1;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                PAUSE: begin
                    if (abort) begin
                        state_reg     <= IDLE;
                        busy_reg      <= 1'b0;
                        cfg_ready_reg <= 1'b1;
                    end else if (!pause) begin
                        state_reg <= RUN;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign count     = count_reg;
    assign busy      = busy_reg;
    assign cfg_ready = cfg_ready_reg;
    assign wrap      = wrap_reg;
    assign done      = done_reg;
    assign cfg_err   = cfg_err_reg;

endmodule

// File: doc/range_counter_ctrl.md
RANGE_COUNTER_CTRL -- requirements
Module: range_counter_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, counter and bound width in bits.
REQ-002 Parameter: PASS_W, 4, width of the pass-count field.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: cfg_valid  input  1  configuration request.
REQ-006 Port: cfg_ready  output  1  controller can accept a configuration.
REQ-007 Port: cfg_lo  input  WIDTH  lower bound, unsigned.
REQ-008 Port: cfg_hi  input  WIDTH  upper bound, unsigned.
REQ-009 Port: cfg_passes  input  PASS_W  number of full sweeps; 0 means continuous.
REQ-010 Port: cfg_down  input  1  1 selects down-count (hi to lo), 0 selects up-count (lo to hi).
REQ-011 Port: start  input  1  begin counting.
REQ-012 Port: pause  input  1  level; holds the count while high.
REQ-013 Port: abort  input  1  terminate the run.
REQ-014 Port: count  output  WIDTH  current count value, registered.
REQ-015 Port: busy  output  1  high in RUN or PAUSE.
REQ-016 Port: wrap  output  1  one-cycle pulse on each completed, non-final sweep.
REQ-017 Port: done  output  1  one-cycle pulse when the final sweep completes.
REQ-018 Port: cfg_err  output  1  one-cycle pulse when a configuration is rejected.

Function
REQ-019 FSM states SHALL be IDLE, ARMED, RUN and PAUSE; all outputs SHALL be registered.
REQ-020 cfg_ready SHALL be 1 in IDLE and ARMED, and 0 in RUN and PAUSE.
REQ-021 A configuration SHALL be accepted on an edge with cfg_valid && cfg_ready.
- If cfg_lo > cfg_hi: cfg_err pulses for one cycle; the state and the stored configuration are unchanged.
- Otherwise: lo, hi, passes and down are latched; count is loaded with the start value (lo if up, hi if down); the pass counter clears; the next state is ARMED.
REQ-022 In ARMED, a further accepted configuration SHALL replace the stored one under the same rules as REQ-021.
REQ-023 In ARMED, start=1 SHALL move the FSM to RUN on that edge; count first changes on the following edge.
- start SHALL be ignored in IDLE, RUN and PAUSE.
REQ-024 In RUN, count SHALL change on every edge:
- +1 when up; -1 when down.
- Arithmetic is modulo 2^WIDTH.
REQ-025 End value SHALL be hi (up mode) or lo (down mode). When count equals the end value in RUN, the next edge SHALL do one of the following:
- Sweeps remaining (passes == 0, or pass counter + 1 < passes): reload the start value, pulse wrap, increment the pass counter.
- Final sweep: hold count at the end value, pulse done, go to IDLE.
REQ-026 Self-correction: if count is outside [lo,hi] in RUN, the next edge SHALL reload the start value, with no wrap and no pass increment.
REQ-027 If lo == hi, every RUN edge SHALL be an end-of-sweep event.
REQ-028 In RUN, pause=1 SHALL move the FSM to PAUSE with count held; in PAUSE, pause=0 SHALL return the FSM to RUN.
REQ-029 abort=1 in ARMED, RUN or PAUSE SHALL move the FSM to IDLE on that edge:
- count held;
- no done and no wrap;
- stored configuration retained.
REQ-030 Priority per edge SHALL be: rst > abort > pause > end/wrap/count.
- A pause arriving on the end-of-sweep edge holds count and suppresses wrap and done for that edge.
REQ-031 busy SHALL be 1 exactly when the state is RUN or PAUSE.
REQ-032 The pass counter SHALL saturate at its maximum value when passes == 0.

Reset
REQ-033 rst=1 on an edge SHALL set the outputs and state to:
- state IDLE;
- count 0;
- stored lo, hi, passes, down and the pass counter 0;
- busy, wrap, done and cfg_err 0;
- cfg_ready 1 on the following cycle.
REQ-034 rst SHALL override every other input, including rst asserted mid-run or in the same cycle as start, cfg_valid or abort.

Verification
REQ-035 Configure lo=10, hi=40, up, passes=1, then start -> count 10,11,...,40 over 30 RUN edges; on the next edge count=40, done=1 for one cycle, state IDLE, busy=0.
REQ-036 Configure lo=10, hi=40, up, passes=0, run 70 edges -> wrap pulses on the edges where count goes 40->10; no done; busy stays 1.
REQ-037 Configure lo=5, hi=8, down, passes=2 -> count 8,7,6,5,8(wrap),7,6,5; then done with count=5.
REQ-038 Configure lo=40, hi=10 -> cfg_err=1 for one cycle; state remains IDLE; count unchanged.
REQ-039 Mid-run tests:
- pause high for 3 cycles at count=20 -> count holds 20 for 3 cycles, then resumes at 21.
- abort at count=25 -> IDLE, count=25, done=0.
REQ-040 Assert rst during RUN at count=33 -> next cycle count=0, state IDLE, cfg_ready=1, busy=0.
